// File: rtl/apb_slave_regbank_pkg.sv
// ---------------------------------------------------------------------------
// apb_regbank_pkg
// Shared types and constants for the APB register-bank completer.
//   apb_state_t  : APB phase tracker states (IDLE, SETUP, ACCESS)
//   APB_DATA_W   : APB data width
//   APB_ADDR_W   : APB address width
//   NSEL         : width of the one-hot Pselx bus from the bridge
//   clog2()      : index width helper (returns at least 1)
// ---------------------------------------------------------------------------
package apb_regbank_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;
  localparam int NSEL       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank_if
// APB bus bundle between the AHB-to-APB bridge (master) and the register
// bank (slave), plus the bank's status outputs.
//   Pselx/Penable/Pwrite/Paddr/Pwdata : bridge -> bank
//   Prdata                            : bank -> bridge (combinational)
//   wr_cnt/rd_cnt                     : saturating completed-transfer counters
//   prot_err                          : sticky protocol-violation flag
//
// Handshake: Pselx[SEL_IDX] acts as the valid for a transfer. There is no
// ready: a transfer always takes one SETUP cycle (Penable=0) followed by one
// ACCESS cycle (Penable=1), and the slave accepts it unconditionally at the
// end of the ACCESS cycle. Address, direction and write data must be held
// stable across both cycles.
// ---------------------------------------------------------------------------
interface apb_slave_regbank_if
  import apb_regbank_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [NSEL-1:0]       Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [APB_ADDR_W-1:0] Paddr;
  logic [APB_DATA_W-1:0] Pwdata;
  logic [APB_DATA_W-1:0] Prdata;
  logic [CNT_W-1:0]      wr_cnt;
  logic [CNT_W-1:0]      rd_cnt;
  logic                  prot_err;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, wr_cnt, rd_cnt, prot_err
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, wr_cnt, rd_cnt, prot_err
  );

endinterface

// File: rtl/apb_slave_regbank_prot_checker.sv
// ---------------------------------------------------------------------------
// apb_prot_checker
// Watches the APB bus seen by the register bank and raises a sticky error on:
//   - Penable high with this slave selected while the phase tracker is IDLE
//   - Paddr, Pwrite or Pwdata changing between SETUP and ACCESS
//   - more than one Pselx bit set
// Only instantiated when APB_SLV_PROT_CHECK_EN is defined.
// Ports:
//   Hclk, Hreset  : clock, async active-high reset
//   i_state       : current phase-tracker state of the bank
//   i_pselx       : full one-hot select bus
//   i_psel        : this slave's select bit
//   i_penable, i_pwrite, i_paddr, i_pwdata : APB inputs
//   o_prot_err    : sticky violation flag
// ---------------------------------------------------------------------------
module apb_prot_checker
  import apb_regbank_pkg::*;
(
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  apb_state_t            i_state,
  input  logic [NSEL-1:0]       i_pselx,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [APB_ADDR_W-1:0] i_paddr,
  input  logic [APB_DATA_W-1:0] i_pwdata,
  output logic                  o_prot_err
);

  logic [APB_ADDR_W-1:0] r_setup_addr;
  logic [APB_DATA_W-1:0] r_setup_wdata;
  logic                  r_setup_write;
  logic                  r_prot_err;

  logic w_setup_cycle;
  logic w_access_cycle;
  logic w_idle_penable;
  logic w_changed;
  logic w_multi_sel;

  // The tracker lags the bus by one cycle: the bus SETUP cycle is seen while
  // the tracker is IDLE or ACCESS, the bus ACCESS cycle while it is SETUP.
  assign w_setup_cycle  = (i_state != SETUP) && i_psel && !i_penable;
  assign w_access_cycle = (i_state == SETUP) && i_psel && i_penable;
  assign w_idle_penable = (i_state == IDLE) && i_psel && i_penable;
  assign w_changed      = w_access_cycle &&
                          ((i_paddr  != r_setup_addr)  ||
                           (i_pwrite != r_setup_write) ||
                           (i_pwdata != r_setup_wdata));
  assign w_multi_sel    = (i_pselx & (i_pselx - 1'b1)) != '0;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_setup_addr  <= '0;
      r_setup_wdata <= '0;
      r_setup_write <= 1'b0;
      r_prot_err    <= 1'b0;
    end else begin
      if (w_setup_cycle) begin
        r_setup_addr  <= i_paddr;
        r_setup_wdata <= i_pwdata;
        r_setup_write <= i_pwrite;
      end
      if (w_idle_penable || w_changed || w_multi_sel) r_prot_err <= 1'b1;
    end
  end

  assign o_prot_err = r_prot_err;

endmodule

// File: rtl/apb_slave_regbank.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank
// APB completer on one Pselx line of the AHB-to-APB bridge. Holds NUM_REGS
// 32-bit read/write registers, tracks APB phases with a small FSM and keeps
// saturating read/write transfer counters. No Pready: each transfer is one
// SETUP plus one ACCESS cycle.
// Parameters: SEL_IDX (select bit), NUM_REGS (power of two, 2..256),
//             ADDR_LSB (first index bit of Paddr), CNT_W (counter width).
// Ports:
//   Hclk, Hreset : bus clock, async active-high reset
//   bus          : apb_slave_regbank_if.slave (APB signals, counters, prot_err)
//   o_dbg_state  : current phase-tracker state
// Build option: define APB_SLV_PROT_CHECK_EN to build the protocol checker;
// otherwise prot_err is tied to 0.
// ---------------------------------------------------------------------------
module apb_slave_regbank
  import apb_regbank_pkg::*;
#(
  parameter int SEL_IDX  = 0,
  parameter int NUM_REGS = 16,
  parameter int ADDR_LSB = 2,
  parameter int CNT_W    = 16
) (
  input  logic                Hclk,
  input  logic                Hreset,
  apb_slave_regbank_if.slave  bus,
  output apb_state_t          o_dbg_state
);

  localparam int IDX_W   = clog2(NUM_REGS);
  localparam int TOP_LSB = ADDR_LSB + IDX_W;

  apb_state_t r_state;
  apb_state_t w_state_nxt;

  logic [APB_DATA_W-1:0] r_regs [NUM_REGS];
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [CNT_W-1:0]      r_rd_cnt;

  logic             w_psel;
  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_complete;
  logic             w_wr_commit;
  logic             w_unused_bits;

  assign w_psel     = bus.Pselx[SEL_IDX];
  assign w_idx      = bus.Paddr[ADDR_LSB +: IDX_W];
  assign w_in_range = (bus.Paddr >> TOP_LSB) == '0;
  assign w_unused_bits = ^{bus.Pselx, bus.Paddr};

  // Phase tracker.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_psel && !bus.Penable) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = (w_psel && bus.Penable)  ? ACCESS : IDLE;
      ACCESS:  w_state_nxt = (w_psel && !bus.Penable) ? SETUP  : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

  // A transfer completes on the edge that loads ACCESS: the bus is in its
  // ACCESS cycle right now and the tracker saw its SETUP cycle last cycle.
  // Committing here lets a read in the very next cycle see the new value.
  assign w_complete  = (w_state_nxt == ACCESS);
  assign w_wr_commit = w_complete && bus.Pwrite && w_in_range;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_commit) begin
      r_regs[w_idx] <= bus.Pwdata;
    end
  end

  // Out-of-range writes are dropped above but still counted here.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (w_complete) begin
      if (bus.Pwrite) begin
        if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      end else begin
        if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.wr_cnt = r_wr_cnt;
  assign bus.rd_cnt = r_rd_cnt;

  // Read mux is combinational so data is valid in both SETUP and ACCESS.
  assign bus.Prdata = (w_psel && !bus.Pwrite && w_in_range) ? r_regs[w_idx] : '0;

`ifdef APB_SLV_PROT_CHECK_EN
  apb_prot_checker u_prot_checker (
    .Hclk       (Hclk),
    .Hreset     (Hreset),
    .i_state    (r_state),
    .i_pselx    (bus.Pselx),
    .i_psel     (w_psel),
    .i_penable  (bus.Penable),
    .i_pwrite   (bus.Pwrite),
    .i_paddr    (bus.Paddr),
    .i_pwdata   (bus.Pwdata),
    .o_prot_err (bus.prot_err)
  );
`else
  assign bus.prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regbank.sv
module tb_apb_slave_regbank;
  import apb_regbank_pkg::*;

  localparam int CNT_W    = 4;
  localparam int NUM_REGS = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef APB_SLV_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       Hclk = 1'b0;
  logic       Hreset;
  apb_state_t dbg_state;

  always #5 Hclk = ~Hclk;

  apb_slave_regbank_if #(.CNT_W(CNT_W)) bus ();

  apb_slave_regbank #(
    .SEL_IDX(0), .NUM_REGS(NUM_REGS), .ADDR_LSB(2), .CNT_W(CNT_W)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset), .bus(bus), .o_dbg_state(dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_regs [NUM_REGS];
  int          m_wr, m_rd;
  bit          m_prot;
  logic [31:0] exp_q [$];
  int          n_vec, n_err;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a / 4) < NUM_REGS;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] sel, input bit wr,
                                         input logic [31:0] a);
    if (sel[0] && !wr && in_range(a)) return m_regs[(a / 4) % NUM_REGS];
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
    m_wr = 0; m_rd = 0; m_prot = 1'b0;
  endtask

  task automatic model_apply(input logic [2:0] sel, input bit wr,
                             input logic [31:0] a, input logic [31:0] d);
    if (sel[0]) begin
      if (wr) begin
        m_wr++;
        if (in_range(a)) m_regs[(a / 4) % NUM_REGS] = d;
      end else begin
        m_rd++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    bus.Paddr = 32'h0;  bus.Pwdata  = 32'h0;
  endtask

  task automatic idle_cycle();
    bus_idle();
    @(posedge Hclk); #1;
  endtask

  task automatic do_reset();
    bus_idle();
    Hreset = 1'b1;
    @(posedge Hclk); @(posedge Hclk); #1;
    Hreset = 1'b0;
    model_reset();
  endtask

  // One SETUP + ACCESS transfer. Returns Prdata and FSM state sampled at the
  // falling edge of each phase; returns 1 time unit after the ACCESS edge.
  task automatic xfer(input logic [2:0] sel, input bit wr, input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd_s, output logic [31:0] rd_a,
                      output apb_state_t st_s, output apb_state_t st_a);
    bus.Pselx = sel; bus.Penable = 1'b0; bus.Pwrite = wr;
    bus.Paddr = a;   bus.Pwdata  = d;
    @(negedge Hclk); rd_s = bus.Prdata; st_s = dbg_state;
    @(posedge Hclk); #1;
    bus.Penable = 1'b1;
    @(negedge Hclk); rd_a = bus.Prdata; st_a = dbg_state;
    @(posedge Hclk); #1;
    model_apply(sel, wr, a, d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Hreset = 1'b1;
    bus_idle();
    bus.Pselx = 3'b001;
    @(posedge Hclk); @(negedge Hclk);
    model_reset();
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d need %0d", dbg_state, IDLE); end
    n_vec++; if (bus.Prdata !== 32'h0) begin n_err++; $display("FAIL reset_prdata: got %h need 0", bus.Prdata); end
    n_vec++; if (bus.wr_cnt !== '0) begin n_err++; $display("FAIL reset_wr_cnt: got %0d need 0", bus.wr_cnt); end
    n_vec++; if (bus.rd_cnt !== '0) begin n_err++; $display("FAIL reset_rd_cnt: got %0d need 0", bus.rd_cnt); end
    n_vec++; if (bus.prot_err !== 1'b0) begin n_err++; $display("FAIL reset_prot_err: got %b need 0", bus.prot_err); end
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_write_read();
    logic [31:0] rs, ra; apb_state_t ss, sa;
    xfer(3'b001, 1'b1, 32'h08, 32'hDEAD_BEEF, rs, ra, ss, sa);
    n_vec++; if (ss !== IDLE || sa !== SETUP) begin n_err++; $display("FAIL wr_states: got %0d/%0d need %0d/%0d", ss, sa, IDLE, SETUP); end
    idle_cycle();
    xfer(3'b001, 1'b0, 32'h08, 32'h0, rs, ra, ss, sa);
    n_vec++; if (rs !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_setup_data: got %h need deadbeef", rs); end
    n_vec++; if (ra !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_access_data: got %h need deadbeef", ra); end
    n_vec++; if (bus.wr_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL basic_wr_cnt: got %0d need 1", bus.wr_cnt); end
    n_vec++; if (bus.rd_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL basic_rd_cnt: got %0d need 1", bus.rd_cnt); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] rs, ra, e; apb_state_t ss, sa;
    addrs[0] = 32'h00; addrs[1] = 32'h04; addrs[2] = 32'h3C;
    for (int i = 0; i < 3; i++) begin
      xfer(3'b001, 1'b1, addrs[i], $urandom, rs, ra, ss, sa);
      if (i > 0) begin
        n_vec++; if (ss !== ACCESS || sa !== SETUP) begin n_err++; $display("FAIL b2b_states[%0d]: got %0d/%0d need %0d/%0d", i, ss, sa, ACCESS, SETUP); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      e = exp_rd(3'b001, 1'b0, addrs[i]);
      xfer(3'b001, 1'b0, addrs[i], 32'h0, rs, ra, ss, sa);
      n_vec++; if (rs !== e || ra !== e) begin n_err++; $display("FAIL b2b_read[%0d]: got %h/%h need %h", i, rs, ra, e); end
    end
    n_vec++; if (bus.wr_cnt !== CNT_W'(sat(m_wr))) begin n_err++; $display("FAIL b2b_wr_cnt: got %0d need %0d", bus.wr_cnt, sat(m_wr)); end
    idle_cycle();
  endtask

  task automatic test_out_of_range();
    logic [31:0] rs, ra, e; apb_state_t ss, sa;
    xfer(3'b001, 1'b1, 32'h40, $urandom, rs, ra, ss, sa);
    n_vec++; if (bus.wr_cnt !== CNT_W'(sat(m_wr))) begin n_err++; $display("FAIL oor_wr_cnt: got %0d need %0d", bus.wr_cnt, sat(m_wr)); end
    idle_cycle();
    xfer(3'b001, 1'b0, 32'h40, 32'h0, rs, ra, ss, sa);
    n_vec++; if (rs !== 32'h0 || ra !== 32'h0) begin n_err++; $display("FAIL oor_read: got %h/%h need 0", rs, ra); end
    for (int i = 0; i < NUM_REGS; i++) begin
      e = exp_rd(3'b001, 1'b0, 32'(i * 4));
      xfer(3'b001, 1'b0, 32'(i * 4), 32'h0, rs, ra, ss, sa);
      n_vec++; if (ra !== e) begin n_err++; $display("FAIL oor_bank[%0d]: got %h need %h", i, ra, e); end
    end
    idle_cycle();
  endtask

  task automatic test_other_sel();
    logic [31:0] rs, ra, e; apb_state_t ss, sa;
    int wr0, rd0;
    wr0 = m_wr; rd0 = m_rd;
    xfer(3'b010, 1'b1, 32'h00, 32'hA5A5_5A5A, rs, ra, ss, sa);
    n_vec++; if (rs !== 32'h0 || ra !== 32'h0) begin n_err++; $display("FAIL sel_prdata: got %h/%h need 0", rs, ra); end
    n_vec++; if (bus.wr_cnt !== CNT_W'(sat(wr0)) || bus.rd_cnt !== CNT_W'(sat(rd0))) begin n_err++; $display("FAIL sel_counters: got %0d/%0d need %0d/%0d", bus.wr_cnt, bus.rd_cnt, sat(wr0), sat(rd0)); end
    idle_cycle();
    e = exp_rd(3'b001, 1'b0, 32'h00);
    xfer(3'b001, 1'b0, 32'h00, 32'h0, rs, ra, ss, sa);
    n_vec++; if (ra !== e) begin n_err++; $display("FAIL sel_reg0: got %h need %h", ra, e); end
    idle_cycle();
  endtask

  task automatic test_random();
    logic [31:0] rs, ra, a, d, e; apb_state_t ss, sa;
    bit wr, last_wr;
    logic [31:0] last_a;
    last_wr = 1'b0; last_a = 32'h0;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        a = ($urandom_range(1, 255) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      else
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if (last_wr && $urandom_range(0, 1) == 1) begin
        wr = 1'b0; a = last_a;  // read straight after write, same word
      end else if ($urandom_range(0, 2) == 0) begin
        idle_cycle();
      end
      d = $urandom;
      exp_q.push_back(exp_rd(3'b001, wr, a));
      xfer(3'b001, wr, a, d, rs, ra, ss, sa);
      e = exp_q.pop_front();
      n_vec++; if (rs !== e || ra !== e) begin n_err++; $display("FAIL rand_prdata[%0d] a=%h wr=%0b: got %h/%h need %h", i, a, wr, rs, ra, e); end
      n_vec++; if (bus.wr_cnt !== CNT_W'(sat(m_wr)) || bus.rd_cnt !== CNT_W'(sat(m_rd))) begin n_err++; $display("FAIL rand_cnt[%0d]: got %0d/%0d need %0d/%0d", i, bus.wr_cnt, bus.rd_cnt, sat(m_wr), sat(m_rd)); end
      last_wr = wr; last_a = a;
    end
    idle_cycle();
  endtask

  task automatic test_idle_penable();
    logic [31:0] rs, ra, e; apb_state_t ss, sa;
    do_reset();
    idle_cycle();
    bus.Pselx = 3'b001; bus.Penable = 1'b1; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h04; bus.Pwdata = 32'hCAFE_F00D;
    @(posedge Hclk); @(negedge Hclk);
    m_prot = 1'b1;
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL idle_pen_state: got %0d need %0d", dbg_state, IDLE); end
    @(posedge Hclk); #1;
    bus_idle();
    n_vec++; if (bus.wr_cnt !== '0 || bus.rd_cnt !== '0) begin n_err++; $display("FAIL idle_pen_cnt: got %0d/%0d need 0/0", bus.wr_cnt, bus.rd_cnt); end
    n_vec++; if (bus.prot_err !== (PROT_EN & m_prot)) begin n_err++; $display("FAIL idle_pen_prot: got %b need %b", bus.prot_err, PROT_EN & m_prot); end
    e = exp_rd(3'b001, 1'b0, 32'h04);
    xfer(3'b001, 1'b0, 32'h04, 32'h0, rs, ra, ss, sa);
    n_vec++; if (ra !== e) begin n_err++; $display("FAIL idle_pen_reg: got %h need %h", ra, e); end
    idle_cycle();
  endtask

  task automatic test_prot();
    logic [31:0] rs, ra, e, d; apb_state_t ss, sa;
    do_reset();
    idle_cycle();
    d = $urandom;
    bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h04; bus.Pwdata = d;
    @(posedge Hclk); #1;
    bus.Paddr = 32'h08; bus.Penable = 1'b1;
    @(posedge Hclk); #1;
    model_apply(3'b001, 1'b1, 32'h08, d);
    m_prot = 1'b1;
    bus_idle();
    @(negedge Hclk);
    n_vec++; if (bus.prot_err !== (PROT_EN & m_prot)) begin n_err++; $display("FAIL prot_addr_change: got %b need %b", bus.prot_err, PROT_EN & m_prot); end
    @(posedge Hclk); #1;
    e = exp_rd(3'b001, 1'b0, 32'h08);
    xfer(3'b001, 1'b0, 32'h08, 32'h0, rs, ra, ss, sa);
    n_vec++; if (ra !== e) begin n_err++; $display("FAIL prot_commit: got %h need %h", ra, e); end
    n_vec++; if (bus.wr_cnt !== CNT_W'(sat(m_wr))) begin n_err++; $display("FAIL prot_wr_cnt: got %0d need %0d", bus.wr_cnt, sat(m_wr)); end
    idle_cycle(); idle_cycle();
    n_vec++; if (bus.prot_err !== (PROT_EN & m_prot)) begin n_err++; $display("FAIL prot_sticky: got %b need %b", bus.prot_err, PROT_EN & m_prot); end
    do_reset();
    n_vec++; if (bus.prot_err !== 1'b0) begin n_err++; $display("FAIL prot_cleared: got %b need 0", bus.prot_err); end
    bus.Pselx = 3'b110;
    @(posedge Hclk); #1;
    bus_idle();
    m_prot = 1'b1;
    n_vec++; if (bus.prot_err !== (PROT_EN & m_prot)) begin n_err++; $display("FAIL prot_multi_sel: got %b need %b", bus.prot_err, PROT_EN & m_prot); end
    idle_cycle();
  endtask

  task automatic test_mid_reset();
    logic [31:0] rs, ra; apb_state_t ss, sa;
    idle_cycle();
    bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h04; bus.Pwdata = 32'h1234;
    #2 Hreset = 1'b1;
    model_reset();
    @(negedge Hclk);
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL midrst_state: got %0d need %0d", dbg_state, IDLE); end
    n_vec++; if (bus.wr_cnt !== '0 || bus.rd_cnt !== '0 || bus.prot_err !== 1'b0 || bus.Prdata !== 32'h0) begin n_err++; $display("FAIL midrst_outputs: got %0d/%0d/%b/%h need 0/0/0/0", bus.wr_cnt, bus.rd_cnt, bus.prot_err, bus.Prdata); end
    @(posedge Hclk); #1;
    bus.Penable = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    idle_cycle();
    xfer(3'b001, 1'b0, 32'h04, 32'h0, rs, ra, ss, sa);
    n_vec++; if (ra !== 32'h0) begin n_err++; $display("FAIL midrst_reg1: got %h need 0", ra); end
    n_vec++; if (bus.wr_cnt !== '0) begin n_err++; $display("FAIL midrst_wr_cnt: got %0d need 0", bus.wr_cnt); end
    idle_cycle();
  endtask

  task automatic test_saturate();
    logic [31:0] rs, ra; apb_state_t ss, sa;
    do_reset();
    idle_cycle();
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      xfer(3'b001, 1'b1, 32'((i % NUM_REGS) * 4), $urandom, rs, ra, ss, sa);
      n_vec++; if (bus.wr_cnt !== CNT_W'(sat(m_wr))) begin n_err++; $display("FAIL sat_wr_cnt[%0d]: got %0d need %0d", i, bus.wr_cnt, sat(m_wr)); end
    end
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      xfer(3'b001, 1'b0, 32'((i % NUM_REGS) * 4), 32'h0, rs, ra, ss, sa);
      n_vec++; if (bus.rd_cnt !== CNT_W'(sat(m_rd))) begin n_err++; $display("FAIL sat_rd_cnt[%0d]: got %0d need %0d", i, bus.rd_cnt, sat(m_rd)); end
    end
    idle_cycle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_other_sel();
    test_random();
    test_idle_penable();
    test_prot();
    test_mid_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
